flag_unit: RTL and testbench
============================

FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; resetb  in  1  asynchronous active-low reset.
REQ-002 The block SHALL provide the remaining ports as follows:
- alu_zero, alu_negative, alu_overflow, alu_c_out  in  1 each  ALU flag results.
- flag_we  in  4  per-flag write enables {N,V,Z,C}.
- c_sel  in  2  ALU carry source: 00/11 = C flag, 01 = force 0, 10 = force 1.
- c_in  out  1  carry to ALU.
- bcd  out  1  decimal mode to ALU (= D flag).
- flag_op_en  in  1  strobe for flag_op.
- flag_op  in  3  0 CLC, 1 SEC, 2 CLI, 3 SEI, 4 CLD, 5 SED, 6 CLV, 7 no-op.
- p_load  in  1  load P from p_din (PLP/RTI).
- p_din  in  8  bus byte.
- p_dout  out  8  P image for push.
- brk_push  in  1  B bit value for push.
- irq_n, nmi_n  in  1 each  external asynchronous interrupt lines, active-low.
- int_ack  in  1  sequencer accepts the pending interrupt.
- int_req  out  1  interrupt pending.
- int_is_nmi  out  1  pending interrupt is NMI.

Function
REQ-003 The block SHALL hold flags N(7) V(6) D(3) I(2) Z(1) C(0) in flops; bits 5 and 4 are not stored.
REQ-004 p_dout SHALL be combinational: {N,V,1,brk_push,D,I,Z,C}.
REQ-005 c_in SHALL be combinational from c_sel and C; bcd SHALL equal D combinationally.
REQ-006 When flag_we[k]=1, the corresponding ALU flag SHALL be captured on the next rising clk edge; updates become visible 1 cycle later.
REQ-007 When flag_op_en=1, the decoded flag SHALL be set or cleared on the next edge; flag_op=7 SHALL change nothing.
REQ-008 When p_load=1, all six stored flags SHALL load from p_din; p_din[5:4] SHALL be ignored.
REQ-009 Per-bit priority SHALL be: p_load > int_ack (sets I) > flag_op > flag_we.
- Non-conflicting sources in one cycle all apply.
- Example: SEC with flag_we[0]=1 gives C=1.
REQ-010 irq_n and nmi_n SHALL each pass a 2-flop synchronizer whose flops reset to 1.
REQ-011 A 1-to-0 transition on synchronized nmi SHALL set nmi_pending on the edge following detection.
- Edge-detect register resets to 1.
- A held-low nmi_n SHALL NOT retrigger.
REQ-012 int_is_nmi SHALL equal nmi_pending.
REQ-013 int_req SHALL be combinational: nmi_pending | (irq_sync==0 & I==0). IRQ is level-sensitive and masked by the registered I.
REQ-014 int_ack SHALL act on the next edge as follows:
- Sets I.
- Clears nmi_pending if int_is_nmi=1.
- If a new NMI edge is detected in the same cycle, nmi_pending SHALL remain 1.
REQ-015 int_ack with int_req=0 SHALL still set I and otherwise have no effect.
REQ-016 CLI while irq_n is held low SHALL raise int_req exactly 1 cycle after the CLI edge.
- Same latency for PLP clearing I.

Reset
REQ-017 While resetb=0, the block SHALL asynchronously force the following values:
- N=V=D=Z=C=0, I=1.
- nmi_pending=0.
- Synchronizer and edge flops = 1.
REQ-018 The resulting outputs during reset SHALL be:
- p_dout=0x24 (brk_push=0) or 0x34 (brk_push=1).
- int_req=0, int_is_nmi=0.
- c_in=0 with c_sel=00, bcd=0.
REQ-019 Deassertion of resetb SHALL take effect at the next rising clk edge; a reset mid-NMI-pending SHALL discard the pending NMI.

Verification
REQ-020 Reset, then brk_push=1, c_sel=00 -> p_dout=0x34, c_in=0, bcd=0, int_req=0.
REQ-021 Load and flag ops:
- p_load with p_din=0xFF -> next cycle p_dout=0xEF (brk_push=0).
- Then CLV, CLD, CLC in three successive cycles -> p_dout=0xA6.
REQ-022 Same-cycle priority:
- alu_c_out=0 with flag_we=0001 and flag_op=SEC -> C=1.
- p_load with p_din=0x00 and int_ack -> I=0.
REQ-023 IRQ masking:
- irq_n held low with I=1 -> int_req=0.
- CLI -> int_req=1 within 3 cycles of CLI (2 sync plus 1 flag).
- int_ack -> I=1, int_req=0 the next cycle.
REQ-024 NMI edge handling:
- nmi_n high->low, held low -> int_req=int_is_nmi=1 by cycle 3, with I=1.
- int_ack -> both 0.
- Holding nmi_n low -> no retrigger.
- nmi_n high then low again -> pending again.
REQ-025 c_sel sweep 00/01/10/11 with C=1 -> c_in = 1,0,1,1; SED -> bcd=1 next cycle.

Source files
------------

// File: rtl/flag_unit.sv
// flag_unit: processor status register (N V D I Z C) with flag update
// priority, carry source selection, and interrupt request generation
// from synchronized IRQ (level, masked by I) and NMI (edge-latched).
module flag_unit (
    input  logic       clk,
    input  logic       resetb,
    input  logic       alu_zero,
    input  logic       alu_negative,
    input  logic       alu_overflow,
    input  logic       alu_c_out,
    input  logic [3:0] flag_we,
    input  logic [1:0] c_sel,
    output logic       c_in,
    output logic       bcd,
    input  logic       flag_op_en,
    input  logic [2:0] flag_op,
    input  logic       p_load,
    input  logic [7:0] p_din,
    output logic [7:0] p_dout,
    input  logic       brk_push,
    input  logic       irq_n,
    input  logic       nmi_n,
    input  logic       int_ack,
    output logic       int_req,
    output logic       int_is_nmi
);

    localparam logic [2:0] OP_CLC = 3'd0;
    localparam logic [2:0] OP_SEC = 3'd1;
    localparam logic [2:0] OP_CLI = 3'd2;
    localparam logic [2:0] OP_SEI = 3'd3;
    localparam logic [2:0] OP_CLD = 3'd4;
    localparam logic [2:0] OP_SED = 3'd5;
    localparam logic [2:0] OP_CLV = 3'd6;

    logic n_q, v_q, d_q, i_q, z_q, c_q;
    logic n_d, v_d, d_d, i_d, z_d, c_d;
    logic irq_s1_q, irq_s2_q, nmi_s1_q, nmi_s2_q, nmi_prev_q, nmi_pending_q;
    logic nmi_pending_d;
    logic nmi_edge_s;
    logic op_s;

    // A falling edge of the synchronized NMI line (prev high, now low).
    assign nmi_edge_s = nmi_prev_q & ~nmi_s2_q;
    assign op_s       = flag_op_en;

    // Next-state flags: p_load beats int_ack beats flag_op beats flag_we, per bit.
    always_comb begin
        n_d = n_q;
        v_d = v_q;
        d_d = d_q;
        i_d = i_q;
        z_d = z_q;
        c_d = c_q;
        if (p_load) begin
            n_d = p_din[7];
            v_d = p_din[6];
            d_d = p_din[3];
            i_d = p_din[2];
            z_d = p_din[1];
            c_d = p_din[0];
        end else begin
            // Lowest priority first so higher-priority sources overwrite.
            if (flag_we[3]) n_d = alu_negative; else n_d = n_q;
            if (flag_we[2]) v_d = alu_overflow; else v_d = v_q;
            if (flag_we[1]) z_d = alu_zero;     else z_d = z_q;
            if (flag_we[0]) c_d = alu_c_out;    else c_d = c_q;
            if (op_s) begin
                case (flag_op)
                    OP_CLC:  c_d = 1'b0;
                    OP_SEC:  c_d = 1'b1;
                    OP_CLI:  i_d = 1'b0;
                    OP_SEI:  i_d = 1'b1;
                    OP_CLD:  d_d = 1'b0;
                    OP_SED:  d_d = 1'b1;
                    OP_CLV:  v_d = 1'b0;
                    default: ; // 7 is a no-op
                endcase
            end else begin
                i_d = i_q;
            end
            if (int_ack) i_d = 1'b1; else i_d = i_d;
        end
    end

    // NMI latch: a new edge always wins over an acknowledge of the old one.
    always_comb begin
        nmi_pending_d = nmi_pending_q;
        if (nmi_edge_s) begin
            nmi_pending_d = 1'b1;
        end else if (int_ack && nmi_pending_q) begin
            nmi_pending_d = 1'b0;
        end else begin
            nmi_pending_d = nmi_pending_q;
        end
    end

    // Carry source for the ALU.
    always_comb begin
        case (c_sel)
            2'b01:   c_in = 1'b0;
            2'b10:   c_in = 1'b1;
            default: c_in = c_q;
        endcase
    end

    assign bcd        = d_q;
    assign p_dout     = {n_q, v_q, 1'b1, brk_push, d_q, i_q, z_q, c_q};
    assign int_is_nmi = nmi_pending_q;
    assign int_req    = nmi_pending_q | (~irq_s2_q & ~i_q);

    // Flag, synchronizer and NMI state registers.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            n_q           <= 1'b0;
            v_q           <= 1'b0;
            d_q           <= 1'b0;
            i_q           <= 1'b1;
            z_q           <= 1'b0;
            c_q           <= 1'b0;
            irq_s1_q      <= 1'b1;
            irq_s2_q      <= 1'b1;
            nmi_s1_q      <= 1'b1;
            nmi_s2_q      <= 1'b1;
            nmi_prev_q    <= 1'b1;
            nmi_pending_q <= 1'b0;
        end else begin
            n_q           <= n_d;
            v_q           <= v_d;
            d_q           <= d_d;
            i_q           <= i_d;
            z_q           <= z_d;
            c_q           <= c_d;
            irq_s1_q      <= irq_n;
            irq_s2_q      <= irq_s1_q;
            nmi_s1_q      <= nmi_n;
            nmi_s2_q      <= nmi_s1_q;
            nmi_prev_q    <= nmi_s2_q;
            nmi_pending_q <= nmi_pending_d;
        end
    end

endmodule

// File: tb/tb_flag_unit.sv
// Directed testbench for flag_unit with hand-computed expectations.
module tb_flag_unit;

    logic       clk = 1'b0;
    logic       resetb;
    logic       alu_zero, alu_negative, alu_overflow, alu_c_out;
    logic [3:0] flag_we;
    logic [1:0] c_sel;
    logic       c_in, bcd;
    logic       flag_op_en;
    logic [2:0] flag_op;
    logic       p_load;
    logic [7:0] p_din, p_dout;
    logic       brk_push, irq_n, nmi_n, int_ack, int_req, int_is_nmi;

    int tests_run = 0;
    int tests_failed = 0;

    flag_unit dut (
        .clk(clk), .resetb(resetb),
        .alu_zero(alu_zero), .alu_negative(alu_negative),
        .alu_overflow(alu_overflow), .alu_c_out(alu_c_out),
        .flag_we(flag_we), .c_sel(c_sel), .c_in(c_in), .bcd(bcd),
        .flag_op_en(flag_op_en), .flag_op(flag_op),
        .p_load(p_load), .p_din(p_din), .p_dout(p_dout),
        .brk_push(brk_push), .irq_n(irq_n), .nmi_n(nmi_n),
        .int_ack(int_ack), .int_req(int_req), .int_is_nmi(int_is_nmi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges; inputs change and outputs are sampled 1 time unit later.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic op(input logic [2:0] code);
        flag_op_en = 1'b1;
        flag_op    = code;
        step(1);
        flag_op_en = 1'b0;
        flag_op    = 3'd7;
    endtask

    initial begin
        resetb = 1'b0;
        alu_zero = 1'b0; alu_negative = 1'b0; alu_overflow = 1'b0; alu_c_out = 1'b0;
        flag_we = 4'b0000; c_sel = 2'b00; flag_op_en = 1'b0; flag_op = 3'd7;
        p_load = 1'b0; p_din = 8'h00; brk_push = 1'b1;
        irq_n = 1'b1; nmi_n = 1'b1; int_ack = 1'b0;

        // Reset values
        #12;
        check("rst_p_dout_brk1", p_dout, 8'h34);
        check("rst_c_in", {7'd0, c_in}, 8'h00);
        check("rst_bcd", {7'd0, bcd}, 8'h00);
        check("rst_int_req", {7'd0, int_req}, 8'h00);
        check("rst_int_is_nmi", {7'd0, int_is_nmi}, 8'h00);
        brk_push = 1'b0;
        #1;
        check("rst_p_dout_brk0", p_dout, 8'h24);
        @(posedge clk); #1;
        resetb = 1'b1;
        step(1);
        check("post_rst_p_dout", p_dout, 8'h24);

        // PLP of 0xFF, bits 5:4 ignored
        p_load = 1'b1; p_din = 8'hFF;
        step(1);
        p_load = 1'b0;
        check("plp_ff", p_dout, 8'hEF);

        op(3'd6);
        check("clv", p_dout, 8'hAF);
        op(3'd4);
        op(3'd0);
        check("clv_cld_clc", p_dout, 8'hA6);

        // SEC beats flag_we[0] with alu_c_out=0
        alu_c_out = 1'b0; flag_we = 4'b0001;
        op(3'd1);
        flag_we = 4'b0000;
        check("sec_over_we", {7'd0, p_dout[0]}, 8'h01);

        // flag_we on N and Z only
        alu_negative = 1'b0; alu_zero = 1'b0; alu_c_out = 1'b0; flag_we = 4'b1010;
        step(1);
        flag_we = 4'b0000;
        check("we_n_z", p_dout, 8'h25);

        // p_load beats int_ack on I
        p_load = 1'b1; p_din = 8'h00; int_ack = 1'b1;
        step(1);
        p_load = 1'b0; int_ack = 1'b0;
        check("plp_over_ack", p_dout, 8'h20);

        // IRQ masking
        op(3'd3);
        irq_n = 1'b0;
        step(3);
        check("irq_masked", {7'd0, int_req}, 8'h00);
        op(3'd2);
        check("cli_irq_req", {7'd0, int_req}, 8'h01);
        int_ack = 1'b1;
        step(1);
        int_ack = 1'b0;
        check("irq_ack_req", {7'd0, int_req}, 8'h00);
        check("irq_ack_i", {7'd0, p_dout[2]}, 8'h01);
        p_load = 1'b1; p_din = 8'h00;
        step(1);
        p_load = 1'b0;
        check("plp_irq_req", {7'd0, int_req}, 8'h01);
        int_ack = 1'b1;
        step(1);
        int_ack = 1'b0;
        irq_n = 1'b1;
        step(2);
        check("irq_release", {7'd0, int_req}, 8'h00);

        // NMI edge detection
        nmi_n = 1'b0;
        step(1);
        check("nmi_c1", {7'd0, int_req}, 8'h00);
        step(1);
        check("nmi_c2", {7'd0, int_is_nmi}, 8'h00);
        step(1);
        check("nmi_c3_req", {7'd0, int_req}, 8'h01);
        check("nmi_c3_is", {7'd0, int_is_nmi}, 8'h01);
        check("nmi_c3_i", {7'd0, p_dout[2]}, 8'h01);
        int_ack = 1'b1;
        step(1);
        int_ack = 1'b0;
        check("nmi_ack_req", {7'd0, int_req}, 8'h00);
        check("nmi_ack_is", {7'd0, int_is_nmi}, 8'h00);
        step(4);
        check("nmi_no_retrig", {7'd0, int_is_nmi}, 8'h00);
        nmi_n = 1'b1;
        step(3);
        nmi_n = 1'b0;
        step(3);
        check("nmi_retrig", {7'd0, int_is_nmi}, 8'h01);

        // Ack in the same cycle as a fresh edge keeps NMI pending
        nmi_n = 1'b1;
        step(3);
        nmi_n = 1'b0;
        step(2);
        int_ack = 1'b1;
        step(1);
        int_ack = 1'b0;
        check("nmi_ack_vs_edge", {7'd0, int_is_nmi}, 8'h01);
        int_ack = 1'b1;
        step(1);
        int_ack = 1'b0;
        check("nmi_ack_final", {7'd0, int_is_nmi}, 8'h00);

        // Reset while NMI pending discards it
        nmi_n = 1'b1;
        step(3);
        nmi_n = 1'b0;
        step(3);
        check("nmi_pre_rst", {7'd0, int_is_nmi}, 8'h01);
        nmi_n = 1'b1;
        resetb = 1'b0;
        #1;
        check("rst_mid_nmi_is", {7'd0, int_is_nmi}, 8'h00);
        check("rst_mid_nmi_req", {7'd0, int_req}, 8'h00);
        check("rst_mid_p_dout", p_dout, 8'h24);
        step(1);
        resetb = 1'b1;
        step(4);
        check("rst_nmi_gone", {7'd0, int_is_nmi}, 8'h00);

        // Carry select sweep with C=1, then SED
        op(3'd1);
        c_sel = 2'b00; #1; check("csel_00", {7'd0, c_in}, 8'h01);
        c_sel = 2'b01; #1; check("csel_01", {7'd0, c_in}, 8'h00);
        c_sel = 2'b10; #1; check("csel_10", {7'd0, c_in}, 8'h01);
        c_sel = 2'b11; #1; check("csel_11", {7'd0, c_in}, 8'h01);
        c_sel = 2'b00;
        check("bcd_before_sed", {7'd0, bcd}, 8'h00);
        op(3'd5);
        check("bcd_sed", {7'd0, bcd}, 8'h01);
        op(3'd7);
        check("noop", p_dout, 8'h2D);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
